// File: rtl/mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// mac_operand_feeder
//
// Buffers 4-bit operand pairs from a producer in a small circular FIFO and
// issues them one at a time to a 4-bit MAC. It waits for mac_done before
// issuing the next pair. A watchdog abandons a pair if the MAC never answers.
//
// Ports
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_wr_valid         producer has a pair on i_wr_a / i_wr_b
//   o_wr_ready         FIFO not full; a pair is taken when valid && ready
//   i_wr_a, i_wr_b     operand pair to enqueue
//   o_mac_a, o_mac_b   registered operands to the MAC, held across the job
//   o_mac_go           one-cycle start pulse (high only in ISSUE)
//   i_mac_done         MAC completion, only looked at in WAIT
//   o_level            pairs held, including the one in flight
//   o_issued_cnt       pairs completed with done (wraps at 256)
//   o_timeout_err      sticky flag, set when a pair is abandoned
//   o_busy             FSM is not IDLE
// ---------------------------------------------------------------------------
module mac_operand_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [3:0]                 i_wr_a,
    input  logic [3:0]                 i_wr_b,
    output logic [3:0]                 o_mac_a,
    output logic [3:0]                 o_mac_b,
    output logic                       o_mac_go,
    input  logic                       i_mac_done,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic [7:0]                 o_issued_cnt,
    output logic                       o_timeout_err,
    output logic                       o_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [3:0]    r_mem_a [DEPTH];
    logic [3:0]    r_mem_b [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [WW-1:0] r_wd;
    logic [3:0]    r_mac_a;
    logic [3:0]    r_mac_b;
    logic [7:0]    r_issued;
    logic          r_terr;

    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_done;
    logic          w_tmo;

    // Full is judged on the registered level, so there is no combinational
    // path from i_wr_valid to o_wr_ready.
    assign w_push = i_wr_valid && (r_level != LW'(DEPTH));
    // The head stays in the FIFO while in flight; it leaves only when its
    // transaction ends, either way.
    assign w_pop  = w_done || w_tmo;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_load       = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over an expiring watchdog
                if (i_mac_done) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wd == WW'(TIMEOUT-1)) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Storage array carries no reset so it maps onto distributed/block RAM;
    // its contents are only read once a slot has been written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= i_wr_a;
            r_mem_b[r_wr_ptr] <= i_wr_b;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_wd     <= '0;
            r_mac_a  <= '0;
            r_mac_b  <= '0;
            r_issued <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (w_load) begin
                r_mac_a <= r_mem_a[r_rd_ptr];
                r_mac_b <= r_mem_b[r_rd_ptr];
            end

            if (r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT && !w_pop) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_done) r_issued <= r_issued + 1'b1;
            if (w_tmo)  r_terr   <= 1'b1;
        end
    end

    assign o_wr_ready    = (r_level != LW'(DEPTH));
    assign o_level       = r_level;
    assign o_mac_a       = r_mac_a;
    assign o_mac_b       = r_mac_b;
    assign o_mac_go      = (r_state == S_ISSUE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_issued_cnt  = r_issued;
    assign o_timeout_err = r_terr;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_feeder
//
// Directed vector table, hand-written corner sequences and a random phase.
// A transaction-level reference model (queue of pairs plus an in-flight age)
// predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_mac_operand_feeder;

    localparam int DEPTH = 8;
    localparam int TO    = 8;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_a;
    logic [3:0]    wr_b;
    logic [3:0]    mac_a;
    logic [3:0]    mac_b;
    logic          mac_go;
    logic          mac_done;
    logic [LW-1:0] level;
    logic [7:0]    issued_cnt;
    logic          timeout_err;
    logic          busy;

    always #5 clk = ~clk;

    mac_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TO)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_a       (wr_a),
        .i_wr_b       (wr_b),
        .o_mac_a      (mac_a),
        .o_mac_b      (mac_b),
        .o_mac_go     (mac_go),
        .i_mac_done   (mac_done),
        .o_level      (level),
        .o_issued_cnt (issued_cnt),
        .o_timeout_err(timeout_err),
        .o_busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    pair_t      m_q[$];        // every pair held, head is the one in flight
    bit         m_inflight;
    int         m_age;         // 0: go cycle, k>=1: k-th cycle waiting for done
    logic [3:0] m_ma, m_mb;
    int         m_issued;
    bit         m_terr;
    pair_t      go_log[$];

    task automatic model_reset();
        m_q.delete();
        m_inflight = 1'b0;
        m_age      = 0;
        m_ma       = 4'd0;
        m_mb       = 4'd0;
        m_issued   = 0;
        m_terr     = 1'b0;
    endtask

    task automatic model_edge(input bit wv, input pair_t wd, input bit done);
        bit acc;
        pair_t dropped;
        acc = wv && (m_q.size() < DEPTH);
        if (!m_inflight) begin
            if (m_q.size() > 0) begin
                m_inflight = 1'b1;
                m_age      = 0;
                m_ma       = m_q[0].a;
                m_mb       = m_q[0].b;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (done) begin
            dropped    = m_q.pop_front();
            m_issued   = (m_issued + 1) % 256;
            m_inflight = 1'b0;
        end else if (m_age == TO) begin
            dropped    = m_q.pop_front();
            m_terr     = 1'b1;
            m_inflight = 1'b0;
        end else begin
            m_age++;
        end
        if (acc) m_q.push_back(wd);
    endtask

    task automatic check_model();
        chk("level",       32'(level),       32'(m_q.size()));
        chk("wr_ready",    32'(wr_ready),    32'(m_q.size() < DEPTH));
        chk("mac_go",      32'(mac_go),      32'(m_inflight && m_age == 0));
        chk("busy",        32'(busy),        32'(m_inflight));
        chk("mac_a",       32'(mac_a),       32'(m_ma));
        chk("mac_b",       32'(mac_b),       32'(m_mb));
        chk("issued_cnt",  32'(issued_cnt),  32'(m_issued));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input bit wv, input logic [3:0] a, input logic [3:0] b, input bit done);
        pair_t p;
        p.a      = a;
        p.b      = b;
        wr_valid = wv;
        wr_a     = a;
        wr_b     = b;
        mac_done = done;
        @(posedge clk);
        #1;
        model_edge(wv, p, done);
        if (mac_go) begin
            go_log.push_back({mac_a, mac_b});
            $display("go   a=%0d b=%0d level=%0d issued=%0d", mac_a, mac_b, level, issued_cnt);
        end
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         wv;
        logic [3:0] a;
        logic [3:0] b;
        bit         done;
        bit         go;
        logic [3:0] ma;
        logic [3:0] mb;
        int         lvl;
        int         iss;
        bit         bsy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int base;
        int pd;

        //            wv a  b  dn | go ma mb lvl iss bsy
        vecs[0]  = '{1, 3, 5, 0,   0, 0, 0, 1,  0,  0};  // single pair, t0
        vecs[1]  = '{0, 0, 0, 0,   1, 3, 5, 1,  0,  1};  // t1: ISSUE
        vecs[2]  = '{0, 0, 0, 0,   0, 3, 5, 1,  0,  1};  // t2: WAIT
        vecs[3]  = '{0, 0, 0, 1,   0, 3, 5, 0,  1,  0};  // t3: done popped
        vecs[4]  = '{1, 1, 2, 0,   0, 3, 5, 1,  1,  0};
        vecs[5]  = '{1, 4, 6, 0,   1, 1, 2, 2,  1,  1};
        vecs[6]  = '{0, 0, 0, 0,   0, 1, 2, 2,  1,  1};
        vecs[7]  = '{1, 7, 9, 1,   0, 1, 2, 2,  2,  0};  // push + pop together
        vecs[8]  = '{0, 0, 0, 0,   1, 4, 6, 2,  2,  1};
        vecs[9]  = '{0, 0, 0, 0,   0, 4, 6, 2,  2,  1};
        vecs[10] = '{0, 0, 0, 1,   0, 4, 6, 1,  3,  0};
        vecs[11] = '{0, 0, 0, 0,   1, 7, 9, 1,  3,  1};
        vecs[12] = '{0, 0, 0, 0,   0, 7, 9, 1,  3,  1};
        vecs[13] = '{0, 0, 0, 1,   0, 7, 9, 0,  4,  0};

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_a     = 4'd0;
        wr_b     = 4'd0;
        mac_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",    32'(level),       0);
        chk("rst_wr_ready", 32'(wr_ready),    1);
        chk("rst_mac_go",   32'(mac_go),      0);
        chk("rst_busy",     32'(busy),        0);
        chk("rst_mac_a",    32'(mac_a),       0);
        chk("rst_issued",   32'(issued_cnt),  0);
        chk("rst_terr",     32'(timeout_err), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].wv, vecs[i].a, vecs[i].b, vecs[i].done);
            chk($sformatf("vec%0d_go", i),     32'(mac_go),     32'(vecs[i].go));
            chk($sformatf("vec%0d_mac_a", i),  32'(mac_a),      32'(vecs[i].ma));
            chk($sformatf("vec%0d_mac_b", i),  32'(mac_b),      32'(vecs[i].mb));
            chk($sformatf("vec%0d_level", i),  32'(level),      32'(vecs[i].lvl));
            chk($sformatf("vec%0d_issued", i), 32'(issued_cnt), 32'(vecs[i].iss));
            chk($sformatf("vec%0d_busy", i),   32'(busy),       32'(vecs[i].bsy));
        end

        // ---- fill to full with the MAC stalled, then release it ----
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 4'(i), 4'(15 - i), 1'b0);
            if (i == 7) chk("fill_ready7", 32'(wr_ready), 1);
            if (i == 8) chk("fill_ready8", 32'(wr_ready), 0);
        end
        chk("fill_level", 32'(level), 8);
        base = go_log.size();
        for (int i = 0; i < 30; i++) step(1'b0, 4'd0, 4'd0, 1'b1);
        chk("fill_go_count", 32'(go_log.size() - base), 7);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("fill_order_a%0d", k), 32'(go_log[base - 2 + k].a), 32'(k));
            chk($sformatf("fill_order_b%0d", k), 32'(go_log[base - 2 + k].b), 32'(15 - k));
        end
        chk("fill_issued", 32'(issued_cnt), 12);

        // ---- done arrives in the very cycle the watchdog expires ----
        step(1'b1, 4'd10, 4'd11, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0);                 // ISSUE
        step(1'b0, 4'd0, 4'd0, 1'b0);                 // enter WAIT
        for (int i = 1; i < TO; i++) step(1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1);                 // TO-th WAIT cycle
        chk("coll_terr",   32'(timeout_err), 0);
        chk("coll_issued", 32'(issued_cnt),  13);
        chk("coll_level",  32'(level),       0);

        // ---- timeout: one pair, MAC never answers ----
        step(1'b1, 4'd2, 4'd3, 1'b0);
        for (int i = 0; i < TO + 1; i++) step(1'b0, 4'd0, 4'd0, 1'b0);
        chk("tmo_level_before", 32'(level),       1);
        chk("tmo_terr_before",  32'(timeout_err), 0);
        step(1'b0, 4'd0, 4'd0, 1'b0);                 // end of TO-th WAIT cycle
        chk("tmo_level_after",  32'(level),       0);
        chk("tmo_terr_after",   32'(timeout_err), 1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 4'd0, 1'b0);
        chk("tmo_terr_sticky",  32'(timeout_err), 1);
        chk("tmo_issued",       32'(issued_cnt),  13);
        step(1'b1, 4'd6, 4'd7, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0);
        chk("tmo_next_go",      32'(mac_go),      1);
        chk("tmo_next_a",       32'(mac_a),       6);
        step(1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1);
        chk("tmo_next_issued",  32'(issued_cnt),  14);

        // ---- asynchronous reset in WAIT with three pairs held ----
        step(1'b1, 4'd1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 4'd2, 1'b0);
        step(1'b1, 4'd3, 4'd3, 1'b0);
        chk("pre_rst_level", 32'(level), 3);
        chk("pre_rst_busy",  32'(busy),  1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level",    32'(level),       0);
        chk("arst_wr_ready", 32'(wr_ready),    1);
        chk("arst_busy",     32'(busy),        0);
        chk("arst_mac_go",   32'(mac_go),      0);
        chk("arst_mac_a",    32'(mac_a),       0);
        chk("arst_mac_b",    32'(mac_b),       0);
        chk("arst_issued",   32'(issued_cnt),  0);
        chk("arst_terr",     32'(timeout_err), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 4'd0, 1'b1);
        chk("post_rst_issued", 32'(issued_cnt), 0);
        chk("post_rst_busy",   32'(busy),       0);

        // ---- random traffic, alternating fast and sluggish MAC ----
        for (int i = 0; i < 400; i++) begin
            pd = ((i / 100) % 2 == 1) ? 5 : 40;
            step($urandom_range(0, 99) < 55, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 99) < pd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Upstream feeder for the 4-bit MAC unit. It buffers operand pairs written by a producer in a small FIFO and issues them one at a time to the MAC's `A`/`B`/`go` inputs. It waits for the MAC's `done` before issuing the next pair, and counts completed issues. A watchdog drops a pair and flags an error if the MAC never answers.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO depth in operand pairs; power of two, at least 2.
- `TIMEOUT`, default 64: cycles in WAIT before a pair is abandoned; at least 2.

Ports:
- `clk` — input, 1 bit: single clock, rising edge.
- `rst` — input, 1 bit: reset, asynchronous and active-high.
- `wr_valid` — input, 1 bit: producer has a pair on `wr_a`/`wr_b`.
- `wr_ready` — output, 1 bit: FIFO not full. A pair is accepted on a rising edge where `wr_valid && wr_ready`.
- `wr_a` — input, 4 bits: operand A to enqueue.
- `wr_b` — input, 4 bits: operand B to enqueue.
- `mac_a` — output, 4 bits: registered operand A driven to the MAC.
- `mac_b` — output, 4 bits: registered operand B driven to the MAC.
- `mac_go` — output, 1 bit: one-cycle start pulse to the MAC.
- `mac_done` — input, 1 bit: completion from the MAC, sampled only in WAIT.
- `level` — output, $clog2(DEPTH+1) bits: number of pairs held, including the one in flight.
- `issued_cnt` — output, 8 bits: pairs completed with `mac_done`; wraps from 255 to 0.
- `timeout_err` — output, 1 bit: sticky; set when a pair is abandoned.
- `busy` — output, 1 bit: state is not IDLE.

## Operation
- FIFO: circular buffer with read/write pointers and an occupancy count.
  - The head entry is popped only when its MAC transaction ends, either by done or by timeout.
  - `wr_ready = (level != DEPTH)`. A write while full is ignored and leaves the FIFO unchanged.
- A push and a pop on the same edge are both performed; `level` is unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if `level != 0`, load `mac_a`/`mac_b` from the FIFO head and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mac_go = 1` for exactly this one cycle; clear the watchdog counter; go to WAIT.
  - WAIT: if `mac_done`, pop the head, increment `issued_cnt`, and go to IDLE.
    - Otherwise, if the watchdog counter equals TIMEOUT-1, pop the head (discard it), set `timeout_err`, and go to IDLE.
    - Otherwise increment the watchdog counter.
- `mac_go` is a Moore output of ISSUE only. It is never high in two consecutive cycles.
- `mac_a`/`mac_b` are held stable from the ISSUE cycle until the next IDLE→ISSUE load. The MAC may sample them at any point during its operation.
- `mac_done` in IDLE or ISSUE is ignored and has no effect.
- `mac_done` and the timeout condition in the same WAIT cycle: done wins; `timeout_err` is not set and `issued_cnt` increments.
- Reset (asynchronous, any state), all to 0:
  - FIFO emptied; pointers and `level` = 0; `wr_ready` = 1.
  - State = IDLE; `mac_go` = 0; `mac_a` = `mac_b` = 0.
  - `issued_cnt` = 0; `timeout_err` = 0; `busy` = 0; watchdog counter = 0.
- Reset mid-transaction drops the in-flight pair. A `mac_done` arriving after reset is ignored because the state is IDLE.

## Timing
- A write is accepted at edge t0; `level` reads 1 after t0.
- Edge t1: state = ISSUE; `mac_a`/`mac_b` are valid; `mac_go` is high during cycle t1–t2.
- Edge t2: state = WAIT.
- Write-to-go latency: `mac_go` rises one cycle after the accepting edge when the FSM is in IDLE.
- If `mac_done` is high in the first WAIT cycle, the pop happens at t3, so minimum `mac_go` pulse spacing is 3 cycles.
- Timeout: with no done, the pair is dropped at the edge ending the TIMEOUT-th WAIT cycle. `timeout_err` is visible in the following cycle.
- `wr_ready` and `level` update on the edge after a push or pop; there is no combinational path from `wr_valid` to `wr_ready`.

## Test plan
- Single pair, fast MAC: write (A=3, B=5) at t0; model `mac_done` one cycle after `mac_go`.
  - Required: `mac_go` high in cycle t1 with `mac_a`=3, `mac_b`=5; `issued_cnt`=1 and `level`=0 after t3; `busy`=0 at t3.
- Fill to full with DEPTH=8: write 9 pairs back-to-back while `mac_done` is held 0.
  - Required: `wr_ready` drops after the 8th accept; the 9th write is ignored; `level`=8.
  - Then release the MAC: pairs 1..8 issue in order with exact operand values.
- Simultaneous push/pop: with `level`=2, write a pair in the same cycle `mac_done` completes the head.
  - Required: `level` stays 2; FIFO order is preserved.
- Timeout: TIMEOUT=4, one pair, `mac_done` never asserted.
  - Required: the pair is dropped 4 cycles after entering WAIT; `timeout_err`=1 and stays 1; `issued_cnt`=0; the next pair still issues normally.
- Done/timeout collision: assert `mac_done` exactly in the TIMEOUT-th WAIT cycle.
  - Required: `timeout_err`=0; `issued_cnt` increments.
- Reset mid-WAIT with `level`=3: assert `rst` asynchronously.
  - Required: all outputs at reset values immediately; a subsequent stray `mac_done` is ignored; `issued_cnt` stays 0.
